// File: rtl/cordic_fix2float.sv
// cordic_fix2float: signed fixed-point (WIDTH+2 bits, WIDTH frac) to IEEE-754 single, one shift per clock, round-nearest-even; in_data/in_valid/in_ready in, out_data/out_valid/out_ready out
module cordic_fix2float #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH+1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t state_q, state_d;
  logic sign_q, sign_d;
  logic [WIDTH+1:0] mag_q, mag_d;
  logic [7:0] exp_q, exp_d, exp_r;
  logic [31:0] data_q, data_d;
  logic [22:0] mant;
  logic [23:0] mant_r;
  logic guard, sticky, up;
  assign mant = mag_q[WIDTH -: 23];
  assign guard = mag_q[WIDTH-23];
  assign sticky = |(mag_q << 25);
  assign up = guard & (sticky | mant[0]);
  assign mant_r = {1'b0, mant} + {23'd0, up};
  assign exp_r = exp_q + {7'd0, mant_r[23]};
  always_comb begin
    state_d = state_q;
    sign_d = sign_q;
    mag_d = mag_q;
    exp_d = exp_q;
    data_d = data_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sign_d = in_data[WIDTH+1];
        mag_d = in_data[WIDTH+1] ? -in_data : in_data;
        exp_d = 8'd128;
        state_d = NORM;
      end
      NORM: if (mag_q == '0) begin
        data_d = '0;
        state_d = DONE;
      end else if (!mag_q[WIDTH+1]) begin
        mag_d = mag_q << 1;
        exp_d = exp_q - 8'd1;
      end else begin
        data_d = {sign_q, exp_r, mant_r[22:0]};
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q <= 1'b0;
      mag_q <= '0;
      exp_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      sign_q <= sign_d;
      mag_q <= mag_d;
      exp_q <= exp_d;
      data_q <= data_d;
    end
  end
  assign in_ready = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_data = data_q;
endmodule

// File: tb/tb_cordic_fix2float.sv
// tb_cordic_fix2float: vector table, corner sequences and random stimulus against a float-rounding model
module tb_cordic_fix2float;
  localparam int W = 24;
  logic clk = 0, rst = 1;
  logic [W+1:0] in_data = '0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [31:0] out_data;
  int checks = 0, errors = 0;
  typedef struct {
    logic [W+1:0] din;
    logic [31:0] dout;
    int lat;
  } vec_t;
  vec_t vecs[9];
  cordic_fix2float #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] ref_float(input logic [W+1:0] d, output int lat);
    longint v, q, rem, half;
    int p, sh, e;
    logic s;
    s = d[W+1];
    v = s ? (longint'(1) << (W + 2)) - longint'(d) : longint'(d);
    if (v == 0) begin
      lat = 1;
      return 32'h0;
    end
    p = 0;
    for (int i = 0; i < W + 2; i++) if ((v >> i) & 1) p = i;
    lat = (W + 1 - p) + 1;
    e = p - W + 127;
    if (p <= 23) q = v << (23 - p);
    else begin
      sh = p - 23;
      q = v >> sh;
      rem = v - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {s, 8'(e), 23'(q)};
  endfunction
  task automatic run(input logic [W+1:0] d, input logic [31:0] exp_o, input int exp_lat, input int hold, input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({nm, " in_ready"}, 32'(in_ready), 32'd1);
    in_data = d;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    in_data = (W+2)'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({nm, " latency"}, 32'(n), 32'(exp_lat));
    check({nm, " data"}, out_data, exp_o);
    repeat (hold) begin
      @(posedge clk); #1;
      check({nm, " held"}, {out_valid, in_ready, out_data[29:0]}, {2'b10, exp_o[29:0]});
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check({nm, " release"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask
  initial begin
    int lat, n;
    logic [W+1:0] d;
    logic [31:0] e;
    vecs[0] = '{26'h1000000, 32'h3F800000, 2};
    vecs[1] = '{26'h3000000, 32'hBF800000, 2};
    vecs[2] = '{26'h2000000, 32'hC0000000, 1};
    vecs[3] = '{26'h0000000, 32'h00000000, 1};
    vecs[4] = '{26'h0000001, 32'h33800000, 26};
    vecs[5] = '{26'h1FFFFFF, 32'h40000000, 2};
    vecs[6] = '{26'h1800000, 32'h3FC00000, 2};
    vecs[7] = '{26'h3FFFFFF, 32'hB3800000, 26};
    vecs[8] = '{26'h0800000, 32'h3F000000, 3};
    repeat (3) @(posedge clk);
    #1;
    check("reset state", {out_data[29:0], out_valid, in_ready}, 32'd0);
    rst = 0;
    #1;
    check("in_ready after reset", 32'(in_ready), 32'd1);
    foreach (vecs[i]) run(vecs[i].din, vecs[i].dout, vecs[i].lat, 0, $sformatf("vec%0d", i));
    run(26'h0800000, 32'h3F000000, 3, 0, "bp accept");
    in_data = 26'h0800000;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data = (W+2)'($urandom);
      @(posedge clk); #1;
      check("bp hold", {out_valid, in_ready, out_data[29:0]}, {2'b10, 30'h3F000000});
      check("bp data", out_data, 32'h3F000000);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("bp release", {30'd0, out_valid, in_ready}, 32'b01);
    @(posedge clk); #1;
    check("bp single transfer", {30'd0, out_valid, in_ready}, 32'b01);
    in_data = 26'h0000001;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1;
    #1;
    check("rst in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("rst mid-norm", {out_data[29:0], out_valid, in_ready}, 32'd0);
    check("rst mid-norm data", out_data, 32'd0);
    rst = 0;
    n = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("no pulse after rst", 32'(n), 32'd0);
    run(26'h1000000, 32'h3F800000, 2, 0, "after rst");
    for (int i = 0; i < 150; i++) begin
      d = (W+2)'($urandom) >> $urandom_range(0, W + 1);
      if ($urandom_range(0, 1)) d = -d;
      e = ref_float(d, lat);
      run(d, e, lat, $urandom_range(0, 2), $sformatf("rand%0d %h", i, d));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
